// File: rtl/pid_chan_sched_pkg.sv
// Shared definitions for the PID channel scheduler: config endpoint map,
// enable-mask init value and the config-address decoder.
package pid_chan_sched_pkg;

    // Config endpoint map (16-bit address space)
    localparam logic [15:0] pid_sched_en_addr      = 16'h0040;
    localparam logic [15:0] pid_sched_ovr_clr_addr = 16'h0041;

    // Per-channel enable value replicated into the enable mask after reset
    localparam logic PID_SCHED_EN_INIT = 1'b1;

    typedef enum logic [1:0] {
        CFG_NONE    = 2'd0,
        CFG_EN      = 2'd1,
        CFG_OVR_CLR = 2'd2
    } cfg_op_e;

    // Map a config address onto the operation it selects
    function automatic cfg_op_e decode_cfg(input logic [15:0] addr);
        if (addr == pid_sched_en_addr) begin
            return CFG_EN;
        end
        if (addr == pid_sched_ovr_clr_addr) begin
            return CFG_OVR_CLR;
        end
        return CFG_NONE;
    endfunction

endpackage

// File: rtl/pid_chan_sched_if.sv
// Config write bus into the scheduler: strobe, endpoint address, target
// channel and data (only bit 0 of the data is meaningful).
interface pid_chan_sched_if #(
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48
) ();
    logic                 wr_en;
    logic [W_WR_ADDR-1:0] wr_addr;
    logic [W_WR_CHAN-1:0] wr_chan;
    logic [W_WR_DATA-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_chan, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_chan, wr_data);
endinterface

// File: rtl/pid_chan_sched_rr_arbiter.sv
// Combinational round-robin picker: the first request at or after the
// pointer wins, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = 5
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_mask[gi] = (W'(gi) >= ptr_i);
    end

    // Requests at/after the pointer take precedence; otherwise wrap around
    assign req_hi = req_i & hi_mask;
    assign pick   = (|req_hi) ? req_hi : req_i;
    assign any_o  = |req_i;

    // Lowest set bit of the selected request set is the winner
    always_comb begin
        idx_o = '0;
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                idx_o    = W'(i);
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pid_chan_sched.sv
// Per-channel sample scheduler ahead of the shared PID filter. Holds the
// newest sample per channel, issues at most one per cycle in round-robin
// order, and keeps each channel out for MIN_GAP cycles after it issues so
// the filter's writeback for that channel lands before it re-enters.
module pid_chan_sched
    import pid_chan_sched_pkg::*;
#(
    parameter int               W_CHAN    = 5,
    parameter int               N_CHAN    = 8,
    parameter int               W_DIN     = 18,
    parameter int               MIN_GAP   = 6,
    parameter logic [N_CHAN-1:0] EN_INIT  = {N_CHAN{PID_SCHED_EN_INIT}},
    parameter int               W_WR_ADDR = 16,
    parameter int               W_WR_CHAN = 16,
    parameter int               W_WR_DATA = 48
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [N_CHAN-1:0]       dv_in,
    input  logic [N_CHAN*W_DIN-1:0] data_in,
    pid_chan_sched_if.slave         cfg_if,
    output logic                    dv_out,
    output logic [W_CHAN-1:0]       chan_out,
    output logic [W_DIN-1:0]        data_out,
    output logic [N_CHAN-1:0]       ovr_out
);
    localparam int W_COOL = $clog2(MIN_GAP) + 1;

    logic [N_CHAN-1:0]             en_q, en_d;
    logic [N_CHAN-1:0]             pending_q, pending_d;
    logic [N_CHAN-1:0]             ovr_q, ovr_d;
    logic [N_CHAN-1:0][W_COOL-1:0] cool_q, cool_d;
    logic [N_CHAN-1:0][W_DIN-1:0]  hold_q, hold_d;
    logic [W_CHAN-1:0]             ptr_q;
    logic                          dv_q;
    logic [W_CHAN-1:0]             chan_q;
    logic [W_DIN-1:0]              data_q;

    logic [N_CHAN-1:0] elig;
    logic [N_CHAN-1:0] win_gnt;
    logic [W_CHAN-1:0] win_idx;
    logic              win_any;
    logic [W_DIN-1:0]  win_data;
    cfg_op_e           cfg_op;
    logic              unused_wr_data;

    assign cfg_op         = decode_cfg(cfg_if.wr_addr);
    assign unused_wr_data = ^cfg_if.wr_data[W_WR_DATA-1:1];

    rr_arbiter #(.N(N_CHAN), .W(W_CHAN)) u_arb (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
        logic wr_hit, cap, iss, ovr_set, dis, clr;

        // wr_chan values >= N_CHAN never match any channel, so they are ignored
        assign wr_hit  = cfg_if.wr_en && (cfg_if.wr_chan == W_WR_CHAN'(gi));
        assign dis     = wr_hit && (cfg_op == CFG_EN) && !cfg_if.wr_data[0];
        assign clr     = wr_hit && (cfg_op == CFG_OVR_CLR) && cfg_if.wr_data[0];
        assign cap     = dv_in[gi] & en_q[gi];
        assign iss     = win_any & win_gnt[gi];
        // A recapture on the issue edge just replaces the issued value: no overrun
        assign ovr_set = cap & pending_q[gi] & ~iss;

        assign elig[gi]      = pending_q[gi] & en_q[gi] & (cool_q[gi] == '0);
        assign en_d[gi]      = (wr_hit && (cfg_op == CFG_EN)) ? cfg_if.wr_data[0] : en_q[gi];
        assign pending_d[gi] = dis ? 1'b0 : (cap ? 1'b1 : (iss ? 1'b0 : pending_q[gi]));
        assign ovr_d[gi]     = ovr_set ? 1'b1 : (clr ? 1'b0 : ovr_q[gi]);
        assign cool_d[gi]    = iss ? W_COOL'(MIN_GAP - 1)
                             : ((cool_q[gi] != '0) ? cool_q[gi] - W_COOL'(1) : cool_q[gi]);
        assign hold_d[gi]    = cap ? data_in[gi*W_DIN +: W_DIN] : hold_q[gi];
    end

    // Held sample of the winning channel (one-hot mux on the grant)
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (win_gnt[i]) begin
                win_data = win_data | hold_q[i];
            end
        end
    end

    // Per-channel state: enable, pending, overrun, cooldown and held sample
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            en_q      <= EN_INIT;
            pending_q <= '0;
            ovr_q     <= '0;
            cool_q    <= '0;
            hold_q    <= '0;
        end else begin
            en_q      <= en_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            cool_q    <= cool_d;
            hold_q    <= hold_d;
        end
    end

    // Registered issue stage and round-robin pointer; chan/data hold when idle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dv_q   <= 1'b0;
            chan_q <= '0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            dv_q <= win_any;
            if (win_any) begin
                chan_q <= win_idx;
                data_q <= win_data;
                ptr_q  <= (win_idx == W_CHAN'(N_CHAN - 1)) ? '0 : win_idx + W_CHAN'(1);
            end
        end
    end

    assign dv_out   = dv_q;
    assign chan_out = chan_q;
    assign data_out = data_q;
    assign ovr_out  = ovr_q;
endmodule
